// File: rtl/reg_file.sv
// 32 x 32 register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] IN,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  input  logic                  WRITE,
  input  logic                  CLK,
  input  logic                  RESET
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic                  wr_en_s;
  logic                  fwd1_s;
  logic                  fwd2_s;

  // A read port yields zero in reset or at x0, the in-flight write data when forwarded, else storage.
  function automatic logic [DATA_WIDTH-1:0] select_read(
    input logic                  rst_ok,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  fwd,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] res;
    if (!rst_ok || (addr == {ADDR_WIDTH{1'b0}})) begin
      res = {DATA_WIDTH{1'b0}};
    end else if (fwd) begin
      res = wdata;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Write qualification: x0 writes are dropped so its storage never leaves zero.
  always_comb begin
    wr_en_s = 1'b0;
    if (RESET && WRITE && (INADDRESS != {ADDR_WIDTH{1'b0}})) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Forwarding hits per read port; constant zero when the feature is compiled out.
  always_comb begin
    fwd1_s = 1'b0;
    fwd2_s = 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (wr_en_s && (INADDRESS == OUT1ADDRESS)) begin
      fwd1_s = 1'b1;
    end else begin
      fwd1_s = 1'b0;
    end
    if (wr_en_s && (INADDRESS == OUT2ADDRESS)) begin
      fwd2_s = 1'b1;
    end else begin
      fwd2_s = 1'b0;
    end
`else
    fwd1_s = 1'b0;
    fwd2_s = 1'b0;
`endif
  end

  // Storage: asynchronous clear of every entry, otherwise at most one entry loads per edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[INADDRESS] <= IN;
    end else begin
      regs_r[INADDRESS] <= regs_r[INADDRESS];
    end
  end

  // Combinational read ports, zero latency.
  always_comb begin
    OUT1 = {DATA_WIDTH{1'b0}};
    OUT2 = {DATA_WIDTH{1'b0}};
    OUT1 = select_read(RESET, OUT1ADDRESS, fwd1_s, IN, regs_r[OUT1ADDRESS]);
    OUT2 = select_read(RESET, OUT2ADDRESS, fwd2_s, IN, regs_r[OUT2ADDRESS]);
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random traffic against an array model.
module tb_reg_file;

  logic [31:0] IN;
  logic [31:0] OUT1;
  logic [31:0] OUT2;
  logic [4:0]  INADDRESS;
  logic [4:0]  OUT1ADDRESS;
  logic [4:0]  OUT2ADDRESS;
  logic        WRITE;
  logic        CLK;
  logic        RESET;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [32];

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .IN(IN), .OUT1(OUT1), .OUT2(OUT2),
    .INADDRESS(INADDRESS), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .WRITE(WRITE), .CLK(CLK), .RESET(RESET)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!RESET) return 32'h0;
    if (a == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (WRITE && (INADDRESS == a)) return IN;
`endif
    return mem[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic probe(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    OUT1ADDRESS = a1;
    OUT2ADDRESS = a2;
    #1;
    chk({tag, "_p1"}, OUT1, exp_read(a1));
    chk({tag, "_p2"}, OUT2, exp_read(a2));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  // Apply the current inputs across one rising edge, then drop WRITE.
  task automatic edge_step();
    if (RESET && WRITE && (INADDRESS != 5'd0)) mem[INADDRESS] = IN;
    @(posedge CLK);
    #1;
    WRITE = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    WRITE = 1'b1;
    INADDRESS = a;
    IN = d;
    edge_step();
  endtask

  initial begin
    logic [31:0] oldv;
    RESET = 1'b0;
    WRITE = 1'b0;
    IN = 32'h0;
    INADDRESS = 5'd0;
    OUT1ADDRESS = 5'd0;
    OUT2ADDRESS = 5'd0;
    clear_model();

    // Reset state with and without the clock running; outputs 0 everywhere.
    #1;
    chk("rst_nclk_p1", OUT1, 32'h0);
    for (int i = 0; i < 32; i++) probe("rst_hold", 5'(i), 5'(31 - i));
    RESET = 1'b1;
    for (int i = 0; i < 32; i++) probe("rst_rel", 5'(i), 5'(i));
    @(posedge CLK);
    #1;

    // Same address on both ports after a write.
    do_write(5'd5, 32'hDEADBEEF);
    probe("x5", 5'd5, 5'd5);
    chk("x5_const1", OUT1, 32'hDEADBEEF);
    chk("x5_const2", OUT2, 32'hDEADBEEF);

    // x0 discards writes, even before the edge.
    WRITE = 1'b1; INADDRESS = 5'd0; IN = 32'hFFFFFFFF;
    probe("x0_pre", 5'd0, 5'd5);
    edge_step();
    probe("x0_post", 5'd0, 5'd0);
    chk("x0_const", OUT1, 32'h0);

    // WRITE low leaves the target untouched.
    do_write(5'd7, 32'h12345678);
    WRITE = 1'b0; INADDRESS = 5'd7; IN = 32'hAAAAAAAA;
    edge_step();
    probe("x7_hold", 5'd7, 5'd5);
    chk("x7_const", OUT1, 32'h12345678);

    // Async reset between edges, then a write attempt during reset.
    do_write(5'd3, 32'h1);
    do_write(5'd4, 32'h2);
    probe("x34", 5'd3, 5'd4);
    RESET = 1'b0;
    clear_model();
    probe("x34_rst", 5'd3, 5'd4);
    chk("x3_rst_const", OUT1, 32'h0);
    WRITE = 1'b1; INADDRESS = 5'd3; IN = 32'h9;
    edge_step();
    RESET = 1'b1;
    probe("x3_after", 5'd3, 5'd4);
    chk("x3_after_const", OUT1, 32'h0);

    // Forwarding window on x10.
    do_write(5'd10, 32'h11110000);
    oldv = 32'h11110000;
    WRITE = 1'b1; INADDRESS = 5'd10; IN = 32'hCAFE0000;
    probe("x10_pre", 5'd10, 5'd7);
`ifdef REG_FILE_BYPASS_EN
    chk("x10_pre_const", OUT1, 32'hCAFE0000);
`else
    chk("x10_pre_const", OUT1, oldv);
`endif
    edge_step();
    probe("x10_post", 5'd10, 5'd10);
    chk("x10_post_const", OUT2, 32'hCAFE0000);

    // Random traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 400; n++) begin
      WRITE = 1'($urandom_range(0, 3) != 0);
      INADDRESS = 5'($urandom);
      IN = $urandom;
      if ($urandom_range(0, 3) == 0) OUT1ADDRESS = INADDRESS;
      else OUT1ADDRESS = 5'($urandom);
      probe("rnd_pre", OUT1ADDRESS, 5'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        RESET = 1'b0;
        clear_model();
        probe("rnd_rst", 5'($urandom), 5'($urandom));
        edge_step();
        RESET = 1'b1;
      end else begin
        edge_step();
      end
      probe("rnd_post", 5'($urandom), INADDRESS);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
